// File: rtl/spi_boot_loader.sv
// SPI-fed SRAM boot loader: framed WRITE/READ/RUN commands over a mode-0 SPI slave.
// Owns the external SRAM while booting, then becomes a transparent Atom-to-SRAM mux.
module spi_boot_loader #(
   parameter int unsigned ADDR_W   = 18,
   parameter int unsigned WR_PULSE = 2,
   parameter int unsigned RD_WAIT  = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              booting,
   output logic              progress,
   output logic [1:0]        boot_error,
   input  logic              SCK,
   input  logic              SSEL,
   input  logic              MOSI,
   output logic              MISO,
   input  logic              atom_RAMCS_b,
   input  logic              atom_RAMOE_b,
   input  logic              atom_RAMWE_b,
   input  logic [ADDR_W-1:0] atom_RAMA,
   input  logic [7:0]        atom_RAMDin,
   output logic              ext_RAMCS_b,
   output logic              ext_RAMOE_b,
   output logic              ext_RAMWE_b,
   output logic [ADDR_W-1:0] ext_RAMA,
   output logic [7:0]        ext_RAMDin,
   input  logic [7:0]        ext_RAMDout
);

   localparam int unsigned TMR_W = 8;

   localparam logic [2:0] F_IDLE  = 3'd0;
   localparam logic [2:0] F_CMD   = 3'd1;
   localparam logic [2:0] F_HDR   = 3'd2;
   localparam logic [2:0] F_WDATA = 3'd3;
   localparam logic [2:0] F_WSUM  = 3'd4;
   localparam logic [2:0] F_RDATA = 3'd5;
   localparam logic [2:0] F_SKIP  = 3'd6;
   localparam logic [2:0] F_DONE  = 3'd7;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_WR   = 2'd1;
   localparam logic [1:0] M_REC  = 2'd2;
   localparam logic [1:0] M_RD   = 2'd3;

   logic [2:0]        sck_s_q, sck_s_d, ssel_s_q, ssel_s_d;
   logic [1:0]        mosi_s_q, mosi_s_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_valid_q, byte_valid_d;
   logic [2:0]        f_state_q, f_state_d;
   logic [1:0]        m_state_q, m_state_d;
   logic [2:0]        hdr_cnt_q, hdr_cnt_d;
   logic              is_rd_q, is_rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        sum_q, sum_d;
   logic [1:0]        err_q, err_d;
   logic              booting_q, booting_d;
   logic [7:0]        tx_q, tx_d;
   logic              miso_q, miso_d;
   logic [7:0]        rd_buf_q, rd_buf_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [ADDR_W-1:0] ram_a_q, ram_a_d;
   logic [7:0]        ram_din_q, ram_din_d;
   logic              we_b_q, we_b_d, oe_b_q, oe_b_d;

   logic              sck_rise, sck_fall, ssel_rise, ssel_fall, ssel_act;
   logic              rd_start, wr_start;
   logic [ADDR_W-1:0] rd_addr, addr_hdr;

   assign sck_rise  =  sck_s_q[1] & ~sck_s_q[2];
   assign sck_fall  = ~sck_s_q[1] &  sck_s_q[2];
   assign ssel_rise =  ssel_s_q[1] & ~ssel_s_q[2];
   assign ssel_fall = ~ssel_s_q[1] &  ssel_s_q[2];
   assign ssel_act  = ~ssel_s_q[1];
   assign addr_hdr  = {addr_q[ADDR_W-9:0], shift_q};

   // Synchronisers and the MOSI byte assembler
   always_comb begin
      sck_s_d      = {sck_s_q[1:0], SCK};
      ssel_s_d     = {ssel_s_q[1:0], SSEL};
      mosi_s_d     = {mosi_s_q[0], MOSI};
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      if (!ssel_act) begin
         bit_cnt_d = 3'd0;
      end else if (sck_rise) begin
         shift_d      = {shift_q[6:0], mosi_s_q[1]};
         bit_cnt_d    = bit_cnt_q + 3'd1;
         byte_valid_d = (bit_cnt_q == 3'd7) && (f_state_q != F_DONE);
      end
   end

   // Frame FSM, memory sequencer and readback shifter
   always_comb begin
      f_state_d = f_state_q;
      m_state_d = m_state_q;
      hdr_cnt_d = hdr_cnt_q;
      is_rd_d   = is_rd_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      err_d     = err_q;
      booting_d = booting_q;
      tx_d      = tx_q;
      rd_buf_d  = rd_buf_q;
      tmr_d     = tmr_q;
      ram_a_d   = ram_a_q;
      ram_din_d = ram_din_q;
      we_b_d    = we_b_q;
      oe_b_d    = oe_b_q;
      rd_start  = 1'b0;
      wr_start  = 1'b0;
      rd_addr   = addr_q;

      // The fall right after a byte's 8th rise exposes the freshly loaded MSB, so it must not shift
      if (sck_fall && ssel_act && (bit_cnt_q != 3'd0)) tx_d = {tx_q[6:0], 1'b1};

      case (f_state_q)
         F_IDLE: if (ssel_fall) f_state_d = F_CMD;
         F_DONE: ;
         default: begin
            if (ssel_rise) begin
               f_state_d = F_IDLE;
               if ((f_state_q == F_HDR) || (f_state_q == F_WDATA) || (f_state_q == F_WSUM))
                  err_d[1] = 1'b1;
            end else if (byte_valid_q) begin
               case (f_state_q)
                  F_CMD: begin
                     sum_d     = 8'd0;
                     cnt_d     = 16'd0;
                     hdr_cnt_d = 3'd0;
                     is_rd_d   = (shift_q == 8'h02);
                     if ((shift_q == 8'h01) || (shift_q == 8'h02)) begin
                        f_state_d = F_HDR;
                     end else if (shift_q == 8'h03) begin
                        f_state_d = F_DONE;
                        booting_d = 1'b0;
                     end else begin
                        f_state_d = F_SKIP;
                     end
                  end
                  F_HDR: begin
                     hdr_cnt_d = hdr_cnt_q + 3'd1;
                     if (hdr_cnt_q < 3'd3) addr_d = addr_hdr;
                     else                  len_d  = {len_q[7:0], shift_q};
                     if ((hdr_cnt_q == 3'd2) && is_rd_q) begin
                        rd_start = 1'b1;
                        rd_addr  = addr_hdr;
                     end
                     if (hdr_cnt_q == 3'd4) begin
                        if (is_rd_q) begin
                           f_state_d = F_RDATA;
                           tx_d      = rd_buf_q;
                           rd_start  = 1'b1;
                        end else begin
                           f_state_d = F_WDATA;
                        end
                     end
                  end
                  F_WDATA: begin
                     wr_start = 1'b1;
                     sum_d    = sum_q + shift_q;
                     if (cnt_q == len_q) f_state_d = F_WSUM;
                     else                cnt_d     = cnt_q + 16'd1;
                  end
                  F_WSUM: begin
                     if (8'(sum_q + shift_q) != 8'd0) err_d[0] = 1'b1;
                     f_state_d = F_IDLE;
                  end
                  F_RDATA: begin
                     tx_d     = rd_buf_q;
                     rd_start = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      endcase

      case (m_state_q)
         M_IDLE: begin
            if (wr_start) begin
               ram_a_d   = addr_q;
               ram_din_d = shift_q;
               we_b_d    = 1'b0;
               tmr_d     = '0;
               m_state_d = M_WR;
            end else if (rd_start) begin
               ram_a_d   = rd_addr;
               oe_b_d    = 1'b0;
               tmr_d     = '0;
               m_state_d = M_RD;
            end
         end
         M_WR: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_q == TMR_W'(WR_PULSE - 1)) begin
               we_b_d    = 1'b1;
               m_state_d = M_REC;
            end
         end
         M_REC: begin
            addr_d    = addr_q + ADDR_W'(1);
            m_state_d = M_IDLE;
         end
         M_RD: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (tmr_q == TMR_W'(RD_WAIT - 1)) begin
               rd_buf_d  = ext_RAMDout;
               oe_b_d    = 1'b1;
               addr_d    = addr_q + ADDR_W'(1);
               m_state_d = M_IDLE;
            end
         end
         default: m_state_d = M_IDLE;
      endcase

      miso_d = (f_state_d == F_RDATA) ? tx_d[7] : 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_s_q      <= 3'b000;
         ssel_s_q     <= 3'b111;
         mosi_s_q     <= 2'b00;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         byte_valid_q <= 1'b0;
         f_state_q    <= F_IDLE;
         m_state_q    <= M_IDLE;
         hdr_cnt_q    <= 3'd0;
         is_rd_q      <= 1'b0;
         addr_q       <= '0;
         len_q        <= 16'd0;
         cnt_q        <= 16'd0;
         sum_q        <= 8'd0;
         err_q        <= 2'b00;
         booting_q    <= 1'b1;
         tx_q         <= 8'hFF;
         miso_q       <= 1'b1;
         rd_buf_q     <= 8'd0;
         tmr_q        <= '0;
         ram_a_q      <= '0;
         ram_din_q    <= 8'd0;
         we_b_q       <= 1'b1;
         oe_b_q       <= 1'b1;
      end else begin
         sck_s_q      <= sck_s_d;
         ssel_s_q     <= ssel_s_d;
         mosi_s_q     <= mosi_s_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         f_state_q    <= f_state_d;
         m_state_q    <= m_state_d;
         hdr_cnt_q    <= hdr_cnt_d;
         is_rd_q      <= is_rd_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         sum_q        <= sum_d;
         err_q        <= err_d;
         booting_q    <= booting_d;
         tx_q         <= tx_d;
         miso_q       <= miso_d;
         rd_buf_q     <= rd_buf_d;
         tmr_q        <= tmr_d;
         ram_a_q      <= ram_a_d;
         ram_din_q    <= ram_din_d;
         we_b_q       <= we_b_d;
         oe_b_q       <= oe_b_d;
      end
   end

   assign booting     = booting_q;
   assign progress    = byte_valid_q;
   assign boot_error  = err_q;
   assign MISO        = miso_q;
   assign ext_RAMCS_b = booting_q ? 1'b0      : atom_RAMCS_b;
   assign ext_RAMOE_b = booting_q ? oe_b_q    : atom_RAMOE_b;
   assign ext_RAMWE_b = booting_q ? we_b_q    : atom_RAMWE_b;
   assign ext_RAMA    = booting_q ? ram_a_q   : atom_RAMA;
   assign ext_RAMDin  = booting_q ? ram_din_q : atom_RAMDin;

endmodule

// File: tb/tb_spi_boot_loader.sv
// Bench for spi_boot_loader: SPI master tasks, behavioural SRAM, and a frame-level
// reference memory/error model checked against SRAM contents and MISO readback.
`timescale 1ns/1ps
module tb_spi_boot_loader;

   localparam int unsigned ADDR_W   = 18;
   localparam int unsigned WR_PULSE = 2;
   localparam int unsigned MEM_SZ   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              booting, progress, MISO;
   logic [1:0]        boot_error;
   logic              SCK, SSEL, MOSI;
   logic              atom_RAMCS_b, atom_RAMOE_b, atom_RAMWE_b;
   logic [ADDR_W-1:0] atom_RAMA;
   logic [7:0]        atom_RAMDin;
   logic              ext_RAMCS_b, ext_RAMOE_b, ext_RAMWE_b;
   logic [ADDR_W-1:0] ext_RAMA;
   logic [7:0]        ext_RAMDin, ext_RAMDout;

   spi_boot_loader #(.ADDR_W(ADDR_W), .WR_PULSE(WR_PULSE), .RD_WAIT(2)) dut (
      .clk(clk), .reset(reset), .booting(booting), .progress(progress),
      .boot_error(boot_error), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO),
      .atom_RAMCS_b(atom_RAMCS_b), .atom_RAMOE_b(atom_RAMOE_b), .atom_RAMWE_b(atom_RAMWE_b),
      .atom_RAMA(atom_RAMA), .atom_RAMDin(atom_RAMDin),
      .ext_RAMCS_b(ext_RAMCS_b), .ext_RAMOE_b(ext_RAMOE_b), .ext_RAMWE_b(ext_RAMWE_b),
      .ext_RAMA(ext_RAMA), .ext_RAMDin(ext_RAMDin), .ext_RAMDout(ext_RAMDout)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM plus activity monitors
   logic [7:0] sram    [0:MEM_SZ-1];
   logic [7:0] exp_mem [0:MEM_SZ-1];
   int we_low = 0, we_pulses = 0, we_bad = 0, oe_low = 0, prog_cnt = 0;

   assign ext_RAMDout = ext_RAMOE_b ? 8'h00 : sram[ext_RAMA];

   always @(posedge clk) begin
      if (!ext_RAMCS_b && !ext_RAMWE_b) sram[ext_RAMA] <= ext_RAMDin;
      if (!ext_RAMWE_b) begin
         we_low <= we_low + 1;
      end else if (we_low != 0) begin
         we_pulses <= we_pulses + 1;
         if (we_low != WR_PULSE) we_bad <= we_bad + 1;
         we_low <= 0;
      end
      if (!ext_RAMOE_b) oe_low <= oe_low + 1;
      if (progress) prog_cnt <= prog_cnt + 1;
   end

   int          n_checks = 0, n_errors = 0;
   logic [1:0]  exp_err;
   int          bytes_exp;
   bit          count_prog;
   logic [7:0]  wbuf [0:15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [ADDR_W-1:0] wrap_a(input logic [23:0] a, input int i);
      return ADDR_W'(a + 24'(i));
   endfunction

   task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         MOSI = d[i];
         repeat (5) @(negedge clk);
         SCK = 1'b1;
         r[i] = MISO;
         repeat (5) @(negedge clk);
         SCK = 1'b0;
      end
      if (count_prog) bytes_exp++;
   endtask

   task automatic frame_open();
      SSEL = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic frame_close();
      repeat (10) @(negedge clk);
      SSEL = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] a, input int len);
      logic [7:0]  r;
      logic [15:0] l;
      l = 16'(len - 1);
      spi_byte(cmd, r);
      spi_byte(a[23:16], r);
      spi_byte(a[15:8], r);
      spi_byte(a[7:0], r);
      spi_byte(l[15:8], r);
      spi_byte(l[7:0], r);
   endtask

   // Sends wbuf[0..len-1]; stop >= 0 aborts after that many data bytes
   task automatic write_frame(input logic [23:0] a, input int len, input bit bad, input int stop);
      logic [7:0] r, sum;
      int n;
      n = (stop >= 0) ? stop : len;
      sum = 8'h00;
      frame_open();
      send_hdr(8'h01, a, len);
      for (int i = 0; i < n; i++) begin
         spi_byte(wbuf[i], r);
         exp_mem[wrap_a(a, i)] = wbuf[i];
         sum = sum + wbuf[i];
      end
      if (stop < 0) begin
         spi_byte(8'(8'h00 - sum + (bad ? 8'h01 : 8'h00)), r);
         if (bad) exp_err[0] = 1'b1;
      end else begin
         exp_err[1] = 1'b1;
      end
      frame_close();
   endtask

   task automatic read_frame(input logic [23:0] a, input int len);
      logic [7:0] r;
      frame_open();
      send_hdr(8'h02, a, len);
      for (int i = 0; i < len; i++) begin
         spi_byte(8'h00, r);
         check("miso_read_byte", r, exp_mem[wrap_a(a, i)]);
      end
      frame_close();
   endtask

   task automatic check_mem(input logic [23:0] a, input int len);
      for (int i = 0; i < len; i++) check("sram_content", sram[wrap_a(a, i)], exp_mem[wrap_a(a, i)]);
   endtask

   initial begin
      int          p0, o0, len;
      logic [23:0] a;
      logic [7:0]  r, saved;
      logic        t_oe, t_we;
      logic [ADDR_W-1:0] t_a;
      logic [7:0]  t_d;

      reset = 1'b1; SCK = 1'b0; SSEL = 1'b1; MOSI = 1'b0;
      atom_RAMCS_b = 1'b1; atom_RAMOE_b = 1'b1; atom_RAMWE_b = 1'b1;
      atom_RAMA = '0; atom_RAMDin = 8'h00;
      exp_err = 2'b00; bytes_exp = 0; count_prog = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_booting", booting, 1'b1);
      check("rst_we", ext_RAMWE_b, 1'b1);
      check("rst_miso", MISO, 1'b1);
      check("rst_err", boot_error, 2'b00);
      check("rst_progress", progress, 1'b0);
      check("rst_cs", ext_RAMCS_b, 1'b0);
      check("rst_oe", ext_RAMOE_b, 1'b1);
      check("rst_addr", ext_RAMA, 0);
      check("rst_din", ext_RAMDin, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Directed write then partial readback
      wbuf[0] = 8'hAA; wbuf[1] = 8'h55; wbuf[2] = 8'h01; wbuf[3] = 8'h02;
      p0 = we_pulses;
      write_frame(24'h00C000, 4, 1'b0, -1);
      check_mem(24'h00C000, 4);
      check("we_pulse_count", we_pulses - p0, 4);
      check("we_pulse_width", we_bad, 0);
      check("err_after_write", boot_error, exp_err);
      read_frame(24'h00C001, 3);

      // Random write/readback regions, including discarded high address bits
      for (int k = 0; k < 6; k++) begin
         a   = 24'($urandom);
         len = int'($urandom_range(1, 8));
         for (int i = 0; i < len; i++) wbuf[i] = 8'($urandom);
         p0 = we_pulses;
         write_frame(a, len, 1'b0, -1);
         check_mem(a, len);
         check("we_pulse_count_rand", we_pulses - p0, len);
         read_frame(a, len);
         check("err_rand", boot_error, exp_err);
      end

      // Bad checksum: flagged but data still lands
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
      write_frame(24'h00C000, 4, 1'b1, -1);
      check("err_checksum", boot_error, exp_err);
      check_mem(24'h00C000, 4);

      // Truncated frame, then a normal frame is accepted
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
      write_frame(24'h001234, 4, 1'b0, 2);
      check("err_truncated", boot_error, exp_err);
      check_mem(24'h001234, 2);
      for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
      write_frame(24'h002000, 3, 1'b0, -1);
      check_mem(24'h002000, 3);
      read_frame(24'h002000, 3);

      // Unknown command is skipped without SRAM writes
      p0 = we_pulses;
      frame_open();
      spi_byte(8'h7E, r);
      for (int i = 0; i < 6; i++) spi_byte(8'($urandom), r);
      frame_close();
      check("skip_no_write", we_pulses - p0, 0);
      check("skip_err", boot_error, exp_err);

      // Address wrap at the top of SRAM
      wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
      write_frame(24'h03FFFF, 2, 1'b0, -1);
      check("wrap_top", sram[18'h3FFFF], wbuf[0]);
      check("wrap_zero", sram[18'h00000], wbuf[1]);
      read_frame(24'h03FFFF, 2);
      check("we_width_all", we_bad, 0);

      // RUN hands the SRAM to the Atom
      frame_open();
      spi_byte(8'h03, r);
      count_prog = 1'b0;
      repeat (3) @(negedge clk);
      check("run_booting", booting, 1'b0);
      frame_close();
      for (int k = 0; k < 4; k++) begin
         t_a = ADDR_W'($urandom); t_d = 8'($urandom);
         t_oe = 1'($urandom); t_we = 1'($urandom);
         atom_RAMA = t_a; atom_RAMDin = t_d; atom_RAMOE_b = t_oe; atom_RAMWE_b = t_we;
         #1;
         check("pass_addr", ext_RAMA, t_a);
         check("pass_din", ext_RAMDin, t_d);
         check("pass_oe", ext_RAMOE_b, t_oe);
         check("pass_we", ext_RAMWE_b, t_we);
         check("pass_cs_hi", ext_RAMCS_b, 1'b1);
         @(negedge clk);
      end
      atom_RAMOE_b = 1'b1; atom_RAMWE_b = 1'b1; atom_RAMCS_b = 1'b0;
      #1;
      check("pass_cs_lo", ext_RAMCS_b, 1'b0);
      repeat (3) @(negedge clk);

      // SPI traffic after RUN must not touch the SRAM
      p0 = we_pulses; o0 = oe_low; saved = sram[18'h05000];
      frame_open();
      send_hdr(8'h01, 24'h005000, 1);
      spi_byte(8'h5A, r);
      spi_byte(8'hA6, r);
      frame_close();
      check("post_run_we", we_pulses - p0, 0);
      check("post_run_oe", oe_low - o0, 0);
      check("post_run_mem", sram[18'h05000], saved);
      check("post_run_booting", booting, 1'b0);
      check("post_run_miso", MISO, 1'b1);
      check("post_run_err", boot_error, exp_err);
      check("progress_count", prog_cnt, bytes_exp);

      // Reset restores loader, then reset mid-write releases WE asynchronously
      atom_RAMCS_b = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rerst_booting", booting, 1'b1);
      check("rerst_err", boot_error, 2'b00);
      frame_open();
      send_hdr(8'h01, 24'h000100, 1);
      for (int i = 7; i >= 0; i--) begin
         MOSI = r[i] ^ 1'b1;
         repeat (5) @(negedge clk);
         SCK = 1'b1;
         if (i != 0) begin
            repeat (5) @(negedge clk);
            SCK = 1'b0;
         end
      end
      for (int k = 0; k < 20; k++) begin
         if (!ext_RAMWE_b) break;
         @(negedge clk);
      end
      check("mid_write_we_low", ext_RAMWE_b, 1'b0);
      reset = 1'b1;
      #1;
      check("async_reset_we", ext_RAMWE_b, 1'b1);
      @(negedge clk);
      SCK = 1'b0; SSEL = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("final_booting", booting, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
